aes_ahb_regif: RTL and testbench
================================

AES_AHB_REGIF -- requirements
Module: aes_ahb_regif

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 4, meaning the number of 32-bit key words (legal values 4, 6, 8).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the number of HADDR low bits decoded.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all flops on rising edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports HSEL, HWRITE, HREADY (input, 1 bit), HTRANS (input, 2 bits), HADDR and HWDATA (input, 32 bits): the AHB-Lite slave inputs.
REQ-006 SHALL have ports HRDATA (output, 32 bits), HREADYOUT (output, 1 bit) and HRESP (output, 1 bit): the AHB-Lite slave outputs.
REQ-007 SHALL have port aes_key, output, 32*KEY_WORDS bits; word i is at bits [32i+31:32i].
REQ-008 SHALL have port aes_plaintext, output, 128 bits; word i is at bits [32i+31:32i].
REQ-009 SHALL have port aes_start, output, 1 bit: one-cycle start pulse to the core.
REQ-010 SHALL have ports aes_done (input, 1 bit, one-cycle pulse) and aes_ciphertext (input, 128 bits, valid while aes_done=1).
REQ-011 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-012 SHALL capture the address phase when HSEL=1, HTRANS[1]=1 and HREADY=1, storing HADDR[ADDR_W-1:2] and HWRITE; the access completes in the following data phase.
REQ-013 SHALL use this map (byte offsets): KEYi 0x00+4i (i<8); TEXTi 0x20+4i (i<4); CTRL 0x30; STATUS 0x34; RESULTi 0x40+4i (i<4); all other offsets read 0 and ignore writes.
REQ-014 SHALL ignore writes to KEYi with i>=KEY_WORDS, and those offsets SHALL read 0.
REQ-015 SHALL apply writes at the end of the data phase using HWDATA; reads SHALL drive HRDATA combinationally from the captured address during the data phase.
REQ-016 SHALL define CTRL as: bit0 START (write-1 action, reads 0), bit1 IE (read/write).
REQ-017 SHALL define STATUS as: bit0 BUSY (read-only), bit1 DONE (sticky, write-1-to-clear).
REQ-018 SHALL have a two-state FSM, IDLE and BUSY.
REQ-019 SHALL, on a START write in IDLE, pulse aes_start for exactly one cycle and enter BUSY on the next edge.
REQ-020 SHALL ignore a START write in BUSY: no pulse, OKAY response.
REQ-021 SHALL, on aes_done=1 in BUSY, latch aes_ciphertext into RESULT0..3, set DONE, and return to IDLE.
REQ-022 SHALL ignore aes_done while in IDLE.
REQ-023 SHALL give set priority over clear when aes_done sets DONE in the same cycle as a DONE W1C write.
REQ-024 SHALL drive irq = DONE & IE, registered-free.
REQ-025 SHALL, for a write to KEY/TEXT while BUSY, leave the register unchanged and give a two-cycle ERROR response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1.
REQ-026 SHALL otherwise complete every access with zero wait states (HREADYOUT=1, HRESP=0).
REQ-027 SHALL drive aes_key and aes_plaintext directly from the KEY and TEXT registers, so they are stable throughout BUSY.
REQ-028 SHALL treat HADDR[1:0] and HSIZE as don't-care; only word accesses are supported.

Reset
REQ-029 SHALL, while HRESETn=0, reset all registers, RESULT and IE to 0, set the FSM to IDLE, and drive aes_start=0, irq=0, HRDATA=0, HREADYOUT=1 and HRESP=0.
REQ-030 SHALL, on reset asserted mid-BUSY or mid-ERROR, abort the operation; an aes_done arriving after release SHALL be ignored.

Structure
REQ-031 SHALL place the register offsets, CTRL/STATUS bit positions, HTRANS encodings and FSM state enum in the shared package aes_regif_pkg.
REQ-032 SHALL implement the address-phase capture and two-cycle ERROR sequencer as the sub-module ahb_lite_slave_if; the register file and FSM SHALL remain in aes_ahb_regif.

Verification
REQ-033 SHALL cover the FIPS-197 vector: write KEY = 000102..0f and TEXT = 00112233..ff, write CTRL=0x1, model responds with aes_done and ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> exactly one aes_start pulse, STATUS reads 0x2, and RESULT0..3 read the ciphertext words.
REQ-034 SHALL cover a write of 0xDEADBEEF to TEXT0 while BUSY -> HREADYOUT=0,1 with HRESP=1,1, and TEXT0 unchanged.
REQ-035 SHALL cover CTRL=0x2 (IE set) followed by completion -> irq=1; then write STATUS=0x2 -> irq=0 next cycle; a W1C coinciding with aes_done -> DONE stays 1.
REQ-036 SHALL cover KEY_WORDS=8: write KEY7=0xA5A5A5A5 -> aes_key[255:224]=0xA5A5A5A5; with KEY_WORDS=4 the same write -> reads 0 and aes_key is unchanged.
REQ-037 SHALL cover HRESETn asserted two cycles into BUSY -> STATUS reads 0, and a late aes_done leaves RESULT=0.
REQ-038 SHALL cover back-to-back write then read of KEY0 (0x12345678) -> the read returns 0x12345678 with no wait states.

Source files
------------

// File: rtl/aes_regif_pkg.sv
// aes_regif_pkg: register map, bit positions, AHB encodings and FSM states shared by the AES register interface
package aes_regif_pkg;
    localparam int OFF_KEY    = 'h00;
    localparam int OFF_TEXT   = 'h20;
    localparam int OFF_CTRL   = 'h30;
    localparam int OFF_STATUS = 'h34;
    localparam int OFF_RESULT = 'h40;
    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/ahb_lite_slave_if.sv
// ahb_lite_slave_if: AHB-Lite address-phase capture and two-cycle ERROR response sequencing
module ahb_lite_slave_if
    import aes_regif_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HADDR,
    input  logic              err_req,
    output logic [ADDR_W-3:0] addr,
    output logic              write,
    output logic              wr_en,
    output logic              rd_en,
    output logic              HREADYOUT,
    output logic              HRESP
);
    logic active, err_first, err_second, unused;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            active     <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            err_second <= 1'b0;
        end else begin
            if (HREADY) begin
                active <= HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
                write  <= HWRITE;
                addr   <= HADDR[ADDR_W-1:2];
            end
            err_second <= err_first;
        end

    // second cycle of an error must not re-arm, even if err_req is still high
    assign err_first = active && err_req && !err_second;
    assign HREADYOUT = !err_first;
    assign HRESP     = err_first || err_second;
    assign wr_en     = active && write && !HRESP;
    assign rd_en     = active && !write;
    assign unused    = &{1'b0, HADDR[31:ADDR_W], HADDR[1:0]};
endmodule

// File: rtl/aes_ahb_regif.sv
// aes_ahb_regif: AHB-Lite register file and start/done sequencer for an AES core
module aes_ahb_regif
    import aes_regif_pkg::*;
#(
    parameter int KEY_WORDS = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic                    HWRITE,
    input  logic                    HREADY,
    input  logic [1:0]              HTRANS,
    input  logic [31:0]             HADDR,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [32*KEY_WORDS-1:0] aes_key,
    output logic [127:0]            aes_plaintext,
    output logic                    aes_start,
    input  logic                    aes_done,
    input  logic [127:0]            aes_ciphertext,
    output logic                    irq
);
    state_t state, state_next;
    logic [7:0][31:0] key_q;
    logic [3:0][31:0] text_q, result_q;
    logic ie, done, write, wr_en, rd_en, err_req, start_wr;
    logic is_key, is_text, is_ctrl, is_status, is_result;
    logic [ADDR_W-3:0] addr;
    logic [ADDR_W-1:0] off;
    logic [2:0] kidx;
    logic [1:0] tidx;
    logic [31:0] rdata;

    ahb_lite_slave_if #(.ADDR_W(ADDR_W)) u_if (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .err_req   (err_req),
        .addr      (addr),
        .write     (write),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    assign off       = {addr, 2'b00};
    assign kidx      = off[4:2];
    assign tidx      = off[3:2];
    // key words beyond KEY_WORDS decode as unmapped: never written, read 0
    assign is_key    = off >= ADDR_W'(OFF_KEY) && off < ADDR_W'(OFF_TEXT) && int'(kidx) < KEY_WORDS;
    assign is_text   = off >= ADDR_W'(OFF_TEXT) && off < ADDR_W'(OFF_CTRL);
    assign is_ctrl   = off == ADDR_W'(OFF_CTRL);
    assign is_status = off == ADDR_W'(OFF_STATUS);
    assign is_result = off >= ADDR_W'(OFF_RESULT) && off < ADDR_W'(OFF_RESULT + 16);
    assign err_req   = state == ST_BUSY && write && (is_key || is_text);
    assign start_wr  = wr_en && is_ctrl && HWDATA[CTRL_START];
    assign aes_start = start_wr && state == ST_IDLE;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) state <= ST_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        if (state == ST_IDLE && start_wr) state_next = ST_BUSY;
        if (state == ST_BUSY && aes_done) state_next = ST_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            key_q    <= '0;
            text_q   <= '0;
            result_q <= '0;
            ie       <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (wr_en && is_key) key_q[kidx] <= HWDATA;
            if (wr_en && is_text) text_q[tidx] <= HWDATA;
            if (wr_en && is_ctrl) ie <= HWDATA[CTRL_IE];
            if (state == ST_BUSY && aes_done) begin
                result_q <= aes_ciphertext;
                done     <= 1'b1;
            end else if (wr_en && is_status && HWDATA[STAT_DONE]) done <= 1'b0;
        end

    assign rdata = is_key    ? key_q[kidx]
                 : is_text   ? text_q[tidx]
                 : is_ctrl   ? 32'(ie) << CTRL_IE
                 : is_status ? (32'(done) << STAT_DONE) | (32'(state == ST_BUSY) << STAT_BUSY)
                 : is_result ? result_q[tidx] : '0;

    assign HRDATA        = rd_en ? rdata : '0;
    assign aes_key       = key_q[KEY_WORDS-1:0];
    assign aes_plaintext = text_q;
    assign irq           = done && ie;
endmodule

// File: tb/tb_aes_ahb_regif.sv
// tb_aes_ahb_regif: directed and randomized checks of aes_ahb_regif against a register-level model
module tb_aes_ahb_regif;
    localparam int KW = 4;
    logic HCLK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, aes_done = 0;
    logic [1:0] HTRANS = 0;
    logic [31:0] HADDR = 0, HWDATA = 0;
    logic [127:0] aes_ciphertext = 0;
    logic [31:0] HRDATA, hrdata8;
    logic HREADYOUT, HRESP, aes_start, irq, hreadyout8, hresp8, unused_start8, unused_irq8;
    logic [127:0] aes_plaintext, unused_pt8, aes_key;
    logic [255:0] aes_key8;

    always #5 HCLK = ~HCLK;

    aes_ahb_regif dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADYOUT),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .aes_key(aes_key), .aes_plaintext(aes_plaintext), .aes_start(aes_start),
        .aes_done(aes_done), .aes_ciphertext(aes_ciphertext), .irq(irq)
    );

    aes_ahb_regif #(.KEY_WORDS(8)) dut8 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADYOUT),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(hrdata8), .HREADYOUT(hreadyout8),
        .HRESP(hresp8), .aes_key(aes_key8), .aes_plaintext(unused_pt8), .aes_start(unused_start8),
        .aes_done(aes_done), .aes_ciphertext(aes_ciphertext), .irq(unused_irq8)
    );

    int n_vec = 0, n_bad = 0, start_cnt = 0, exp_starts = 0, last_waits;
    always @(negedge HCLK) if (aes_start) start_cnt++;

    // register-level model of the KEY_WORDS=4 instance (m_key keeps 8 words for the wide instance)
    logic [31:0] m_key[8], m_text[4], m_result[4];
    logic m_ie, m_done, m_busy;
    logic [31:0] last_rd, last_rd8, exp_rd;
    bit last_err, exp_err;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_key[i] = 0;
        for (int i = 0; i < 4; i++) begin m_text[i] = 0; m_result[i] = 0; end
        m_ie = 0; m_done = 0; m_busy = 0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a < 'h20) return (a / 4 < KW) ? m_key[a / 4] : 32'h0;
        if (a < 'h30) return m_text[(a - 'h20) / 4];
        if (a == 'h30) return {30'h0, m_ie, 1'b0};
        if (a == 'h34) return {30'h0, m_done, m_busy};
        if (a >= 'h40 && a < 'h50) return m_result[(a - 'h40) / 4];
        return 32'h0;
    endfunction

    function automatic bit model_write(input int a, input logic [31:0] d);
        if (m_busy && (a < 'h20 ? a / 4 < KW : a < 'h30)) return 1;
        if (a < 'h20) begin if (!m_busy) m_key[a / 4] = d; end
        else if (a < 'h30) m_text[(a - 'h20) / 4] = d;
        else if (a == 'h30) begin
            m_ie = d[1];
            if (d[0] && !m_busy) begin m_busy = 1; exp_starts++; end
        end else if (a == 'h34 && d[1]) m_done = 0;
        return 0;
    endfunction

    function automatic logic [127:0] model_key();
        return {m_key[3], m_key[2], m_key[1], m_key[0]};
    endfunction

    task automatic bus(input bit w, input int a, input logic [31:0] d);
        exp_rd = model_read(a);
        HSEL = 1; HTRANS = 2'b10; HWRITE = w; HADDR = 32'(a) | 32'($urandom_range(0, 3));
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWDATA = d;
        last_waits = 0; last_err = 0;
        while (!HREADYOUT && last_waits < 4) begin
            last_err |= HRESP; last_waits++;
            @(posedge HCLK); #1;
        end
        last_err |= HRESP; last_rd = HRDATA; last_rd8 = hrdata8;
        @(posedge HCLK); #1;
        exp_err = w ? model_write(a, d) : 1'b0;
    endtask

    task automatic core_done(input logic [127:0] ct);
        aes_done = 1; aes_ciphertext = ct;
        @(posedge HCLK); #1;
        aes_done = 0;
        if (m_busy) begin
            m_busy = 0; m_done = 1;
            for (int i = 0; i < 4; i++) m_result[i] = ct[32*i +: 32];
        end
    endtask

    task automatic test_reset();
        HRESETn = 0; model_reset(); #1;
        n_vec++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
        n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_bad++; $display("FAIL rst_resp got rdy=%b resp=%b exp 1/0", HREADYOUT, HRESP); end
        n_vec++; if (aes_start !== 1'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL rst_start_irq got %b/%b exp 0/0", aes_start, irq); end
        n_vec++; if (aes_key !== '0 || aes_plaintext !== '0) begin n_bad++; $display("FAIL rst_key_text got %h/%h exp 0", aes_key, aes_plaintext); end
        repeat (2) @(posedge HCLK); #1;
        HRESETn = 1;
        @(posedge HCLK); #1;
        for (int a = 0; a < 'h50; a += 4) begin
            bus(0, a, 0);
            n_vec++; if (last_rd !== 32'h0) begin n_bad++; $display("FAIL rst_read@%h got %h exp 0", a, last_rd); end
        end
    endtask

    task automatic test_fips();
        logic [31:0] kw[4], tw[4], cw[4];
        int s0;
        kw = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        tw = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        cw = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        for (int i = 0; i < 4; i++) begin bus(1, 4 * i, kw[i]); bus(1, 'h20 + 4 * i, tw[i]); end
        n_vec++; if (aes_key !== 128'h0c0d0e0f08090a0b0405060700010203) begin n_bad++; $display("FAIL fips_key got %h", aes_key); end
        n_vec++; if (aes_plaintext !== 128'hccddeeff8899aabb4455667700112233) begin n_bad++; $display("FAIL fips_text got %h", aes_plaintext); end
        s0 = start_cnt;
        bus(1, 'h30, 32'h1);
        n_vec++; if (start_cnt - s0 !== 1 || last_err) begin n_bad++; $display("FAIL fips_start got pulses=%0d err=%b exp 1/0", start_cnt - s0, last_err); end
        bus(0, 'h34, 0);
        n_vec++; if (last_rd !== 32'h1) begin n_bad++; $display("FAIL fips_status_busy got %h exp 1", last_rd); end
        repeat (3) @(posedge HCLK); #1;
        core_done({cw[3], cw[2], cw[1], cw[0]});
        bus(0, 'h34, 0);
        n_vec++; if (last_rd !== 32'h2) begin n_bad++; $display("FAIL fips_status_done got %h exp 2", last_rd); end
        n_vec++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL fips_one_pulse got %0d exp 1", start_cnt - s0); end
        for (int i = 0; i < 4; i++) begin
            bus(0, 'h40 + 4 * i, 0);
            n_vec++; if (last_rd !== cw[i]) begin n_bad++; $display("FAIL fips_result%0d got %h exp %h", i, last_rd, cw[i]); end
        end
    endtask

    task automatic test_busy_error();
        logic [127:0] pt;
        int s0;
        bus(1, 'h30, 32'h1);
        pt = aes_plaintext; s0 = start_cnt;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h20;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
        n_vec++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin n_bad++; $display("FAIL err_cycle1 got rdy=%b resp=%b exp 0/1", HREADYOUT, HRESP); end
        @(posedge HCLK); #1;
        n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin n_bad++; $display("FAIL err_cycle2 got rdy=%b resp=%b exp 1/1", HREADYOUT, HRESP); end
        @(posedge HCLK); #1;
        bus(0, 'h20, 0);
        n_vec++; if (last_rd !== 32'h00112233) begin n_bad++; $display("FAIL err_text0 got %h exp 00112233", last_rd); end
        n_vec++; if (aes_plaintext !== pt) begin n_bad++; $display("FAIL err_plaintext got %h exp %h", aes_plaintext, pt); end
        bus(1, 'h30, 32'h1);
        n_vec++; if (last_err || last_waits != 0 || start_cnt != s0) begin n_bad++; $display("FAIL busy_start got err=%b waits=%0d pulses=%0d exp 0/0/0", last_err, last_waits, start_cnt - s0); end
        core_done({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_irq();
        logic [127:0] ct;
        bus(1, 'h34, 32'h2);
        bus(1, 'h30, 32'h3);
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_busy got %b exp 0", irq); end
        core_done({$urandom, $urandom, $urandom, $urandom});
        n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_done got %b exp 1", irq); end
        bus(1, 'h34, 32'h2);
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_w1c got %b exp 0", irq); end
        bus(1, 'h30, 32'h3);
        ct = {$urandom, $urandom, $urandom, $urandom};
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h34;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h2; aes_done = 1; aes_ciphertext = ct;
        @(posedge HCLK); #1;
        aes_done = 0; m_busy = 0; m_done = 1;
        for (int i = 0; i < 4; i++) m_result[i] = ct[32*i +: 32];
        bus(0, 'h34, 0);
        n_vec++; if (last_rd !== 32'h2 || irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins got status=%h irq=%b exp 2/1", last_rd, irq); end
        bus(0, 'h40, 0);
        n_vec++; if (last_rd !== ct[31:0]) begin n_bad++; $display("FAIL irq_result0 got %h exp %h", last_rd, ct[31:0]); end
    endtask

    task automatic test_key_words();
        logic [127:0] kb;
        kb = aes_key;
        bus(1, 'h1c, 32'hA5A5A5A5);
        n_vec++; if (aes_key8[255:224] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL kw8_port got %h exp a5a5a5a5", aes_key8[255:224]); end
        n_vec++; if (aes_key !== kb) begin n_bad++; $display("FAIL kw4_port got %h exp %h", aes_key, kb); end
        bus(0, 'h1c, 0);
        n_vec++; if (last_rd !== 32'h0) begin n_bad++; $display("FAIL kw4_read got %h exp 0", last_rd); end
        n_vec++; if (last_rd8 !== 32'hA5A5A5A5 || hreadyout8 !== 1'b1 || hresp8 !== 1'b0) begin n_bad++; $display("FAIL kw8_read got %h rdy=%b resp=%b", last_rd8, hreadyout8, hresp8); end
    endtask

    task automatic test_back_to_back();
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HWDATA = 32'h12345678; HWRITE = 0;
        n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_bad++; $display("FAIL b2b_write_resp got rdy=%b resp=%b exp 1/0", HREADYOUT, HRESP); end
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        m_key[0] = 32'h12345678;
        n_vec++; if (HRDATA !== 32'h12345678 || HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL b2b_read got %h rdy=%b exp 12345678/1", HRDATA, HREADYOUT); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_random();
        int a;
        bit w;
        logic [31:0] d;
        for (int n = 0; n < 120; n++) begin
            if (m_busy && $urandom_range(0, 3) == 0) core_done({$urandom, $urandom, $urandom, $urandom});
            a = $urandom_range(0, 23) * 4; w = 1'($urandom_range(0, 1)); d = $urandom;
            bus(w, a, d);
            n_vec++; if (last_err !== exp_err || last_waits != int'(exp_err)) begin n_bad++; $display("FAIL rnd_resp@%h w=%b got err=%b waits=%0d exp %b", a, w, last_err, last_waits, exp_err); end
            n_vec++; if (last_rd !== (w ? 32'h0 : exp_rd)) begin n_bad++; $display("FAIL rnd_rdata@%h w=%b got %h exp %h", a, w, last_rd, w ? 32'h0 : exp_rd); end
            n_vec++; if (irq !== (m_done & m_ie) || aes_key !== model_key()) begin n_bad++; $display("FAIL rnd_state irq=%b key=%h exp %b %h", irq, aes_key, m_done & m_ie, model_key()); end
        end
        n_vec++; if (start_cnt != exp_starts) begin n_bad++; $display("FAIL rnd_starts got %0d exp %0d", start_cnt, exp_starts); end
    endtask

    task automatic test_reset_busy();
        if (m_busy) core_done(128'h0);
        bus(1, 'h30, 32'h1);
        repeat (2) @(posedge HCLK); #1;
        HRESETn = 0; model_reset(); #1;
        n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL rb_outputs got rdy=%b resp=%b irq=%b", HREADYOUT, HRESP, irq); end
        @(posedge HCLK); #1;
        HRESETn = 1;
        @(posedge HCLK); #1;
        bus(0, 'h34, 0);
        n_vec++; if (last_rd !== 32'h0) begin n_bad++; $display("FAIL rb_status got %h exp 0", last_rd); end
        core_done({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            bus(0, 'h40 + 4 * i, 0);
            n_vec++; if (last_rd !== 32'h0) begin n_bad++; $display("FAIL rb_result%0d got %h exp 0", i, last_rd); end
        end
        bus(0, 'h34, 0);
        n_vec++; if (last_rd !== 32'h0 || aes_key !== '0) begin n_bad++; $display("FAIL rb_late_done got status=%h key=%h exp 0", last_rd, aes_key); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips();
        test_busy_error();
        test_irq();
        test_key_words();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
